// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int BYTE_W = 8;

  // Keep only the low 'bits' bits of a byte; upper bits are don't-care.
  function automatic logic [BYTE_W-1:0] mask_data(input logic [BYTE_W-1:0] b, input int bits);
    logic [BYTE_W-1:0] m;
    m = '0;
    for (int i = 0; i < BYTE_W; i++) begin
      if (i < bits) m[i] = b[i];
    end
    return m;
  endfunction

  // Parity bit over already-masked data: even -> XOR, odd -> inverted XOR.
  function automatic logic parity_of(input logic [BYTE_W-1:0] b, input int mode);
    return (mode == PAR_ODD) ? ~(^b) : ^b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes ahead of the transmitter.
// Push while full is honoured only when a pop happens on the same edge.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = BYTE_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter (start, DATA_BITS LSB first, optional parity, 1-2 stops).
// Optional feature: define UART_TX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry FIFO;
// otherwise a single holding register is used and bytes are accepted only in IDLE.
//
// state  | meaning
// IDLE   | line high, waiting for a byte
// START  | start bit (low) for one bit period
// DATA   | DATA_BITS data bits, LSB first
// PARITY | parity bit (skipped when PARITY=PAR_NONE)
// STOP   | STOP_BITS stop bits (high)
module uart_tx_param #(
  parameter int FREQUENCY  = 10000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_dv,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       tx_done
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = FREQUENCY / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT >= 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: FREQUENCY/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..8");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop_q, stop_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             serial_d;
  logic             done_d;
  logic             ready_q;
  logic             bit_end;
  logic             last_stop_end;
  logic             accept;
  logic             have_next;
  logic             load;
  logic [7:0]       next_byte;
  logic [7:0]       next_data;

  assign accept        = tx_dv && tx_ready;
  assign bit_end       = (cnt_q == CNT_LAST);
  assign last_stop_end = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);
  assign load          = ((state_q == IDLE) || last_stop_end) && have_next;
  assign next_data     = mask_data(next_byte, DATA_BITS);
  assign tx_active     = (state_q != IDLE);

`ifdef UART_TX_FIFO_EN
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  // A byte arriving when the FIFO is empty and the line is free bypasses the FIFO,
  // which keeps the one-cycle start latency from IDLE.
  assign fifo_pop  = load && !fifo_empty;
  assign fifo_push = accept && !(load && fifo_empty);
  assign have_next = !fifo_empty || accept;
  assign next_byte = fifo_empty ? tx_byte : fifo_dout;
  assign tx_ready  = ready_q && !fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (tx_byte),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
`else
  assign have_next = accept;
  assign next_byte = tx_byte;
  assign tx_ready  = ready_q && (state_q == IDLE);
`endif

  // Next-state and next-output logic; a load from IDLE or the final stop period wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = tx_serial;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        serial_d = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          idx_d    = '0;
          serial_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY != PAR_NONE) begin
              state_d  = uart_pkg::PARITY;
              serial_d = par_q;
            end else begin
              state_d  = STOP;
              stop_d   = 1'b0;
              serial_d = 1'b1;
            end
          end else begin
            idx_d    = idx_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            serial_d = shift_q[1];
          end
        end
      end
      uart_pkg::PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          stop_d   = 1'b0;
          serial_d = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            serial_d = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d  = START;
      cnt_d    = '0;
      serial_d = 1'b0;
      shift_d  = next_data;
      par_d    = parity_of(next_data, PARITY);
    end
  end

  // State, datapath and registered line outputs; ready_q keeps tx_ready low through reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_serial <= serial_d;
      tx_done   <= done_d;
      ready_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 5N2), all at
// 10 clocks per bit, checked cycle by cycle against a frame-level line model.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int CPB  = 10;
  localparam int NI   = 4;
  localparam int TMAX = 700;
`ifdef UART_TX_FIFO_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NI-1:0] dv;
  logic [7:0]    byt [NI];
  wire  [NI-1:0] rdy, act, ser, done;

  int checks = 0;
  int errors = 0;

  int cfg_db  [NI] = '{8, 8, 8, 5};
  int cfg_par [NI] = '{0, 1, 2, 0};
  int cfg_sb  [NI] = '{1, 1, 1, 2};

  logic tr_ser [TMAX];
  logic tr_act [TMAX];
  logic tr_done[TMAX];
  logic tr_rdy [TMAX];
  logic ex_ser [TMAX];
  logic ex_act [TMAX];
  logic ex_done[TMAX];
  logic       stim_dv  [TMAX];
  logic [7:0] stim_byte[TMAX];

  always #5 clk = ~clk;

  uart_tx_param #(.FREQUENCY(10000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8n1 (.clk(clk), .reset_n(reset_n), .tx_dv(dv[0]), .tx_byte(byt[0]), .tx_ready(rdy[0]),
           .tx_active(act[0]), .tx_serial(ser[0]), .tx_done(done[0]));
  uart_tx_param #(.FREQUENCY(10000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8e1 (.clk(clk), .reset_n(reset_n), .tx_dv(dv[1]), .tx_byte(byt[1]), .tx_ready(rdy[1]),
           .tx_active(act[1]), .tx_serial(ser[1]), .tx_done(done[1]));
  uart_tx_param #(.FREQUENCY(10000000), .BAUD_RATE(1000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_8o1 (.clk(clk), .reset_n(reset_n), .tx_dv(dv[2]), .tx_byte(byt[2]), .tx_ready(rdy[2]),
           .tx_active(act[2]), .tx_serial(ser[2]), .tx_done(done[2]));
  uart_tx_param #(.FREQUENCY(10000000), .BAUD_RATE(1000000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    u_5n2 (.clk(clk), .reset_n(reset_n), .tx_dv(dv[3]), .tx_byte(byt[3]), .tx_ready(rdy[3]),
           .tx_active(act[3]), .tx_serial(ser[3]), .tx_done(done[3]));

  // ---------------- reference model ----------------
  function automatic int frame_cycles(input int k);
    return (1 + cfg_db[k] + ((cfg_par[k] != 0) ? 1 : 0) + cfg_sb[k]) * CPB;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TMAX; i++) begin
      ex_ser[i]  = 1'b1;
      ex_act[i]  = 1'b0;
      ex_done[i] = 1'b0;
    end
  endtask

  // One frame whose start bit occupies cycle 'start' onward; done pulses right after it.
  task automatic model_frame(input int k, input int start, input logic [7:0] b);
    logic bits[$];
    int   ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_db[k]; i++) begin
      bits.push_back(b[i]);
      if (b[i]) ones++;
    end
    if (cfg_par[k] == 1) bits.push_back((ones % 2) == 1);
    if (cfg_par[k] == 2) bits.push_back((ones % 2) == 0);
    for (int i = 0; i < cfg_sb[k]; i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      for (int j = 0; j < CPB; j++) begin
        ex_ser[start + i*CPB + j] = bits[i];
        ex_act[start + i*CPB + j] = 1'b1;
      end
    end
    ex_done[start + bits.size()*CPB] = 1'b1;
  endtask

  // ---------------- stimulus / observation ----------------
  task automatic stim_clear();
    for (int i = 0; i < TMAX; i++) begin
      stim_dv[i]   = 1'b0;
      stim_byte[i] = 8'($urandom);
    end
  endtask

  // Entered mid-cycle 0 (at a negedge); records cycles 1..n of instance k.
  task automatic run_capture(input int k, input int n);
    tr_rdy[0] = rdy[k];
    dv[k]  = stim_dv[0];
    byt[k] = stim_byte[0];
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      tr_ser[c]  = ser[k];
      tr_act[c]  = act[k];
      tr_done[c] = done[k];
      tr_rdy[c]  = rdy[k];
      dv[k]  = stim_dv[c];
      byt[k] = stim_byte[c];
    end
    dv[k] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    dv = '0;
    for (int i = 0; i < NI; i++) byt[i] = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (ser !== 4'hF)  begin errors++; $display("FAIL reset_serial got %b want 1111", ser); end
    checks++; if (act !== 4'h0)  begin errors++; $display("FAIL reset_active got %b want 0000", act); end
    checks++; if (done !== 4'h0) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
    checks++; if (rdy !== 4'h0)  begin errors++; $display("FAIL reset_ready got %b want 0000", rdy); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (rdy !== 4'hF)  begin errors++; $display("FAIL ready_after_release got %b want 1111", rdy); end
  endtask

  task automatic test_8n1();
    logic [7:0] b;
    for (int t = 0; t < 4; t++) begin
      b = (t == 0) ? 8'hA5 : 8'($urandom);
      model_clear();
      model_frame(0, 1, b);
      stim_clear();
      stim_dv[0] = 1'b1; stim_byte[0] = b;
      run_capture(0, 110);
      checks++;
      if (tr_rdy[0] !== 1'b1) begin errors++; $display("FAIL 8n1_ready_idle got %b want 1", tr_rdy[0]); end
      for (int c = 1; c <= 110; c++) begin
        checks++;
        if (tr_ser[c] !== ex_ser[c] || tr_act[c] !== ex_act[c] || tr_done[c] !== ex_done[c]) begin
          errors++;
          $display("FAIL 8n1 byte %02h cycle %0d ser/act/done got %b%b%b want %b%b%b",
                   b, c, tr_ser[c], tr_act[c], tr_done[c], ex_ser[c], ex_act[c], ex_done[c]);
          break;
        end
      end
      if (t == 0) begin
        checks++;
        if (tr_done[101] !== 1'b1) begin errors++; $display("FAIL 8n1_done_101 got %b want 1", tr_done[101]); end
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] b;
    for (int k = 1; k <= 2; k++) begin
      for (int t = 0; t < 3; t++) begin
        b = (t == 0) ? 8'h07 : 8'($urandom);
        model_clear();
        model_frame(k, 1, b);
        stim_clear();
        stim_dv[0] = 1'b1; stim_byte[0] = b;
        run_capture(k, 120);
        for (int c = 1; c <= 120; c++) begin
          checks++;
          if (tr_ser[c] !== ex_ser[c] || tr_act[c] !== ex_act[c] || tr_done[c] !== ex_done[c]) begin
            errors++;
            $display("FAIL parity%0d byte %02h cycle %0d ser/act/done got %b%b%b want %b%b%b",
                     cfg_par[k], b, c, tr_ser[c], tr_act[c], tr_done[c], ex_ser[c], ex_act[c], ex_done[c]);
            break;
          end
        end
        if (t == 0) begin
          checks++;
          if (tr_ser[96] !== ((k == 1) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL parity%0d_bit_07 got %b want %b", cfg_par[k], tr_ser[96], (k == 1));
          end
          checks++;
          if (tr_done[111] !== 1'b1) begin errors++; $display("FAIL parity%0d_done_111 got %b want 1", cfg_par[k], tr_done[111]); end
        end
      end
    end
  endtask

  task automatic test_5n2();
    logic [7:0] b;
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'hFF : 8'($urandom);
      model_clear();
      model_frame(3, 1, b);
      stim_clear();
      stim_dv[0] = 1'b1; stim_byte[0] = b;
      run_capture(3, 90);
      for (int c = 1; c <= 90; c++) begin
        checks++;
        if (tr_ser[c] !== ex_ser[c] || tr_act[c] !== ex_act[c] || tr_done[c] !== ex_done[c]) begin
          errors++;
          $display("FAIL 5n2 byte %02h cycle %0d ser/act/done got %b%b%b want %b%b%b",
                   b, c, tr_ser[c], tr_act[c], tr_done[c], ex_ser[c], ex_act[c], ex_done[c]);
          break;
        end
      end
      if (t == 0) begin
        checks++;
        if (tr_done[81] !== 1'b1) begin errors++; $display("FAIL 5n2_done_81 got %b want 1", tr_done[81]); end
      end
    end
  endtask

  // Byte input changes after acceptance; without the FIFO, tx_dv is also held high mid-frame.
  task automatic test_latch_and_drop();
    logic [7:0] b;
    b = 8'($urandom);
    model_clear();
    model_frame(0, 1, b);
    stim_clear();
    stim_dv[0] = 1'b1; stim_byte[0] = b;
`ifndef UART_TX_FIFO_EN
    for (int i = 1; i < 60; i++) stim_dv[i] = 1'b1;
`endif
    run_capture(0, 130);
    for (int c = 1; c <= 130; c++) begin
      checks++;
      if (tr_ser[c] !== ex_ser[c] || tr_act[c] !== ex_act[c] || tr_done[c] !== ex_done[c]) begin
        errors++;
        $display("FAIL latch_drop byte %02h cycle %0d ser/act/done got %b%b%b want %b%b%b",
                 b, c, tr_ser[c], tr_act[c], tr_done[c], ex_ser[c], ex_act[c], ex_done[c]);
        break;
      end
    end
`ifndef UART_TX_FIFO_EN
    checks++;
    if (tr_rdy[5] !== 1'b0)   begin errors++; $display("FAIL ready_busy got %b want 0", tr_rdy[5]); end
    checks++;
    if (tr_rdy[101] !== 1'b1) begin errors++; $display("FAIL ready_back_idle got %b want 1", tr_rdy[101]); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] b1, b2;
    int         len, last_dv, n;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    len = frame_cycles(1);
    last_dv = (GAP == 0) ? 1 : len + 1;
    n = 2*len + GAP + 8;
    model_clear();
    model_frame(1, 1, b1);
    model_frame(1, 1 + len + GAP, b2);
    stim_clear();
    for (int i = 0; i <= last_dv; i++) begin
      stim_dv[i]   = 1'b1;
      stim_byte[i] = (i == 0) ? b1 : b2;
    end
    run_capture(1, n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (tr_ser[c] !== ex_ser[c] || tr_act[c] !== ex_act[c] || tr_done[c] !== ex_done[c]) begin
        errors++;
        $display("FAIL back_to_back bytes %02h,%02h cycle %0d ser/act/done got %b%b%b want %b%b%b",
                 b1, b2, c, tr_ser[c], tr_act[c], tr_done[c], ex_ser[c], ex_act[c], ex_done[c]);
        break;
      end
    end
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo();
    logic [7:0] b [6];
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    model_clear();
    for (int i = 0; i < 5; i++) model_frame(0, 1 + i*100, b[i]);
    stim_clear();
    for (int i = 0; i < 6; i++) begin
      stim_dv[i]   = 1'b1;
      stim_byte[i] = b[i];
    end
    run_capture(0, 530);
    for (int c = 1; c <= 530; c++) begin
      checks++;
      if (tr_ser[c] !== ex_ser[c] || tr_act[c] !== ex_act[c] || tr_done[c] !== ex_done[c]) begin
        errors++;
        $display("FAIL fifo cycle %0d ser/act/done got %b%b%b want %b%b%b",
                 c, tr_ser[c], tr_act[c], tr_done[c], ex_ser[c], ex_act[c], ex_done[c]);
        break;
      end
    end
    checks++;
    if (tr_rdy[4] !== 1'b1) begin errors++; $display("FAIL fifo_ready_before_full got %b want 1", tr_rdy[4]); end
    checks++;
    if (tr_rdy[5] !== 1'b0) begin errors++; $display("FAIL fifo_ready_full got %b want 0", tr_rdy[5]); end
  endtask
`endif

  task automatic test_mid_frame_reset();
    logic [7:0] b;
    b = 8'($urandom);
    stim_clear();
    for (int i = 0; i < 4; i++) stim_dv[i] = 1'b1;
    stim_byte[0] = b;
    run_capture(0, 44);
    checks++;
    if (tr_act[44] !== 1'b1) begin errors++; $display("FAIL midreset_in_frame got %b want 1", tr_act[44]); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ser[0] !== 1'b1 || act[0] !== 1'b0 || done[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs ser/act/done/rdy got %b%b%b%b want 1000", ser[0], act[0], done[0], rdy[0]);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      checks++;
      if (ser[0] !== 1'b1 || act[0] !== 1'b0 || done[0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stays_idle cycle %0d ser/act/done got %b%b%b want 100", c, ser[0], act[0], done[0]);
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_5n2();
    test_latch_and_drop();
    test_back_to_back();
`ifdef UART_TX_FIFO_EN
    test_fifo();
`endif
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter FREQUENCY, default 10000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries, power of two >= 2, used only with UART_TX_FIFO_EN.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port reset_n, input, 1 bit, synchronous active-low reset.
REQ-009 SHALL have port tx_dv, input, 1 bit, byte-valid strobe.
REQ-010 SHALL have port tx_byte, input, 8 bits, byte to send; bits above DATA_BITS-1 are ignored.
REQ-011 SHALL have port tx_ready, output, 1 bit, byte accepted on any edge where tx_dv && tx_ready.
REQ-012 SHALL have port tx_active, output, 1 bit, high while a frame is on the line.
REQ-013 SHALL have port tx_serial, output, 1 bit, registered serial line, idle high.
REQ-014 SHALL have port tx_done, output, 1 bit, one-cycle pulse per completed frame.

Function
REQ-015 SHALL fix CLKS_PER_BIT = FREQUENCY/BAUD_RATE (integer), with elaboration error if < 2 or if DATA_BITS, PARITY, STOP_BITS or FIFO_DEPTH are illegal.
REQ-016 SHALL size the bit-period counter $clog2(CLKS_PER_BIT) bits with no wrap before terminal count CLKS_PER_BIT-1.
REQ-017 SHALL run FSM IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE, or -> START directly when another byte is pending.
REQ-018 SHALL hold every bit (start, each data, parity, each stop) on tx_serial for exactly CLKS_PER_BIT cycles.
REQ-019 SHALL send data LSB first; start bit 0; stop bit(s) 1; STOP state lasts STOP_BITS*CLKS_PER_BIT cycles.
REQ-020 SHALL compute parity over the DATA_BITS latched bits: even gives XOR, odd gives ~XOR.
REQ-021 SHALL drive tx_serial low on the edge after acceptance from IDLE (latency 1 cycle).
REQ-022 SHALL pulse tx_done for exactly one cycle, the cycle after the last stop-bit period ends; frame-to-frame gap is 0 cycles when the next byte is pending.
REQ-023 SHALL hold tx_active high from the first start-bit cycle through the last stop-bit cycle, and low in IDLE.
REQ-024 SHALL latch tx_byte at acceptance; later tx_byte changes SHALL NOT affect the frame in flight.
REQ-025 SHALL ignore tx_dv while tx_ready is low (byte dropped, no state change).

Reset
REQ-026 SHALL, on any edge with reset_n low, including mid-frame, enter IDLE, clear counters and the FIFO, and set tx_serial=1, tx_active=0, tx_done=0.
REQ-027 SHALL drive tx_ready=0 during reset and tx_ready=1 on the first edge after release.

Configuration
REQ-028 SHALL use macro UART_TX_FIFO_EN; when defined, accepted bytes enter a FIFO_DEPTH FIFO, tx_ready = !full, and a simultaneous push and pop at full is legal.
REQ-029 SHALL, without UART_TX_FIFO_EN, use a single holding register with tx_ready high only in IDLE; back-to-back frames then have a >= 1 cycle IDLE gap.

Structure
REQ-030 SHALL place the state enum (IDLE, START, DATA, PARITY, STOP) and the parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD) in package uart_pkg.
REQ-031 SHALL implement the FIFO as sub-module uart_tx_fifo (synchronous, push/pop/full/empty), instantiated only under UART_TX_FIFO_EN.

Verification
REQ-032 SHALL cover the 8N1 case, FREQUENCY=10000000, BAUD_RATE=1000000: send 0xA5 -> start low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, stop high 10 cycles, tx_done at cycle 101.
REQ-033 SHALL cover parity: PARITY=1 with 0x07 -> parity bit 1; PARITY=2 with 0x07 -> parity bit 0; frame is 11 bit periods.
REQ-034 SHALL cover DATA_BITS=5, STOP_BITS=2: send 0xFF -> five 1 data bits, stop high 20 cycles, frame 80 cycles.
REQ-035 SHALL cover UART_TX_FIFO_EN, FIFO_DEPTH=4: push 5 bytes on consecutive cycles -> first 5 accepted (1 in flight + 4 stored) and further bytes while tx_ready=0 dropped; frames contiguous, 5 tx_done pulses.
REQ-036 SHALL cover reset mid-frame: reset_n low at data bit 3 -> next edge tx_serial=1, tx_active=0, FIFO empty, no tx_done.
